// File: rtl/morse_pulse_generator.sv
// Morse element player: latches a left-aligned 4-bit letter and plays
// its dots/dashes on led, with one-cycle done strobe at the end.
// Ports: clk, reset (async high), start, symbol[3:0], size[2:0] in;
//        led, busy, done out (decoded from registered state only).
module morse_pulse_generator #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] symbol,
  input  logic [2:0] size,
  output logic       led,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LAST = CW'(3 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sym_q, sym_d;
  logic [2:0]      rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dash_q, dash_d;
  logic            size_ok;
  logic            mark_end;

  assign size_ok  = (size >= 3'd1) && (size <= 3'd4);
  assign mark_end = (cnt_q == (dash_q ? DASH_LAST : DOT_LAST));

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    rem_d   = rem_q;
    dash_d  = dash_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (size_ok) begin
            sym_d   = symbol;
            rem_d   = size;
            dash_d  = symbol[3];
            state_d = S_MARK;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MARK: begin
        if (mark_end) begin
          cnt_d  = '0;
          rem_d  = rem_q - 3'd1;
          sym_d  = {sym_q[2:0], 1'b0};
          // sym_q[2] becomes the head element after this shift
          dash_d = sym_q[2];
          state_d = (rem_q == 3'd1) ? S_DONE : S_SPACE;
        end
      end
      S_SPACE: begin
        if (cnt_q == DOT_LAST) begin
          cnt_d   = '0;
          dash_d  = sym_q[3];
          state_d = S_MARK;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sym_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dash_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dash_q  <= dash_d;
    end
  end

  assign led  = (state_q == S_MARK);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
